// File: rtl/id_ex_shift_stage_pkg.sv
// pipe_pkg: constants, ALU op codes and the ID/EX shift-stage register type
// shared by the ID/EX shift stage, its forwarding mux and its bus interface.
package pipe_pkg;

  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;
  localparam int ALUOP_W = 4;
  localparam int SHAMT_W = 5;

  localparam logic [RADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLT = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRL = 4'd7,
    ALU_SRA = 4'd8
  } alu_op_e;

  // Contents of the EX side of the pipeline register. The shift amount is
  // kept at SHAMT_W bits; the upper bits of ex_sh_a are always zero.
  typedef struct packed {
    logic               valid;
    logic [SHAMT_W-1:0] sh_amt;
    logic [XLEN-1:0]    sh_b;
    logic [ALUOP_W-1:0] alu_op;
    logic [RADDR_W-1:0] rd_addr;
    logic               reg_write;
  } id_ex_t;

  localparam id_ex_t ID_EX_BUBBLE = '0;

  // True when a later-stage writer owns register src. r0 is never forwarded.
  function automatic logic fwd_hit(input logic               we,
                                   input logic [RADDR_W-1:0] rd,
                                   input logic [RADDR_W-1:0] src);
    return we && (rd != REG_ZERO) && (rd == src);
  endfunction

endpackage

// File: rtl/id_ex_shift_stage_if.sv
// id_ex_shift_stage_if: all non-clock/reset signals of the ID/EX shift stage.
//   Control   : stall, flush
//   ID side   : id_valid, id_rs/rt_addr, id_rs/rt_data, id_shamt,
//               id_shift_var, id_alu_op, id_rd_addr, id_reg_write
//   Forwarding: exmem_rd/reg_write/result, memwb_rd/reg_write/result
//   EX side   : ex_valid, ex_sh_a, ex_sh_b, ex_alu_op, ex_rd_addr, ex_reg_write
// master = whoever drives ID/forwarding and consumes EX; slave = the stage.
interface id_ex_shift_stage_if;
  import pipe_pkg::*;

  logic               stall;
  logic               flush;

  logic               id_valid;
  logic [RADDR_W-1:0] id_rs_addr;
  logic [RADDR_W-1:0] id_rt_addr;
  logic [XLEN-1:0]    id_rs_data;
  logic [XLEN-1:0]    id_rt_data;
  logic [SHAMT_W-1:0] id_shamt;
  logic               id_shift_var;
  logic [ALUOP_W-1:0] id_alu_op;
  logic [RADDR_W-1:0] id_rd_addr;
  logic               id_reg_write;

  logic [RADDR_W-1:0] exmem_rd;
  logic               exmem_reg_write;
  logic [XLEN-1:0]    exmem_result;
  logic [RADDR_W-1:0] memwb_rd;
  logic               memwb_reg_write;
  logic [XLEN-1:0]    memwb_result;

  logic               ex_valid;
  logic [XLEN-1:0]    ex_sh_a;
  logic [XLEN-1:0]    ex_sh_b;
  logic [ALUOP_W-1:0] ex_alu_op;
  logic [RADDR_W-1:0] ex_rd_addr;
  logic               ex_reg_write;

  modport master (
    output stall, flush,
    output id_valid, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data,
    output id_shamt, id_shift_var, id_alu_op, id_rd_addr, id_reg_write,
    output exmem_rd, exmem_reg_write, exmem_result,
    output memwb_rd, memwb_reg_write, memwb_result,
    input  ex_valid, ex_sh_a, ex_sh_b, ex_alu_op, ex_rd_addr, ex_reg_write
  );

  modport slave (
    input  stall, flush,
    input  id_valid, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data,
    input  id_shamt, id_shift_var, id_alu_op, id_rd_addr, id_reg_write,
    input  exmem_rd, exmem_reg_write, exmem_result,
    input  memwb_rd, memwb_reg_write, memwb_result,
    output ex_valid, ex_sh_a, ex_sh_b, ex_alu_op, ex_rd_addr, ex_reg_write
  );

endinterface

// File: rtl/id_ex_shift_stage_fwd_mux.sv
// fwd_mux: combinational 3-way operand select for one source register.
//   src_i                      source register index
//   rf_data_i                  register-file read data
//   exmem_rd/we/data_i         EX/MEM writer (highest priority, newest value)
//   memwb_rd/we/data_i         MEM/WB writer
//   data_o                     resolved operand
module fwd_mux
  import pipe_pkg::*;
(
  input  logic [RADDR_W-1:0] src_i,
  input  logic [XLEN-1:0]    rf_data_i,
  input  logic [RADDR_W-1:0] exmem_rd_i,
  input  logic               exmem_we_i,
  input  logic [XLEN-1:0]    exmem_data_i,
  input  logic [RADDR_W-1:0] memwb_rd_i,
  input  logic               memwb_we_i,
  input  logic [XLEN-1:0]    memwb_data_i,
  output logic [XLEN-1:0]    data_o
);

  always_comb begin
    data_o = rf_data_i;
    if (fwd_hit(exmem_we_i, exmem_rd_i, src_i)) begin
      data_o = exmem_data_i;
    end else if (fwd_hit(memwb_we_i, memwb_rd_i, src_i)) begin
      data_o = memwb_data_i;
    end
  end

endmodule

// File: rtl/id_ex_shift_stage.sv
// id_ex_shift_stage: ID/EX pipeline register for shift-class instructions.
//   clk    pipeline clock, rising edge
//   rst_n  asynchronous active-low reset, clears all EX outputs
//   bus    id_ex_shift_stage_if.slave (stall/flush, ID operands, forwarding
//          tuples in; registered shifter operands A/B and control out)
// Per edge: reset > flush (bubble) > stall (hold) > load.
module id_ex_shift_stage
  import pipe_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  id_ex_shift_stage_if.slave  bus
);

  id_ex_t             ex_q;
  id_ex_t             ex_d;
  logic [XLEN-1:0]    fwd_rs;
  logic [XLEN-1:0]    fwd_rt;
  logic [SHAMT_W-1:0] shamt_sel;
  logic               rs_hi_unused;

  fwd_mux u_fwd_rs (
    .src_i        (bus.id_rs_addr),
    .rf_data_i    (bus.id_rs_data),
    .exmem_rd_i   (bus.exmem_rd),
    .exmem_we_i   (bus.exmem_reg_write),
    .exmem_data_i (bus.exmem_result),
    .memwb_rd_i   (bus.memwb_rd),
    .memwb_we_i   (bus.memwb_reg_write),
    .memwb_data_i (bus.memwb_result),
    .data_o       (fwd_rs)
  );

  fwd_mux u_fwd_rt (
    .src_i        (bus.id_rt_addr),
    .rf_data_i    (bus.id_rt_data),
    .exmem_rd_i   (bus.exmem_rd),
    .exmem_we_i   (bus.exmem_reg_write),
    .exmem_data_i (bus.exmem_result),
    .memwb_rd_i   (bus.memwb_rd),
    .memwb_we_i   (bus.memwb_reg_write),
    .memwb_data_i (bus.memwb_result),
    .data_o       (fwd_rt)
  );

  // The shifter downstream uses all of A, so only the low SHAMT_W bits of a
  // variable amount may survive (sllv by 33 must shift by 1).
  assign shamt_sel    = bus.id_shift_var ? fwd_rs[SHAMT_W-1:0] : bus.id_shamt;
  assign rs_hi_unused = ^fwd_rs[XLEN-1:SHAMT_W];

  always_comb begin
    ex_d = ex_q;
    if (bus.flush) begin
      ex_d = ID_EX_BUBBLE;
    end else if (!bus.stall) begin
      // Operands are captured even for an invalid slot; only valid and the
      // write enable are forced low.
      ex_d.valid     = bus.id_valid;
      ex_d.sh_amt    = shamt_sel;
      ex_d.sh_b      = fwd_rt;
      ex_d.alu_op    = bus.id_alu_op;
      ex_d.rd_addr   = bus.id_rd_addr;
      ex_d.reg_write = bus.id_reg_write & bus.id_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= ID_EX_BUBBLE;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign bus.ex_valid     = ex_q.valid;
  assign bus.ex_sh_a      = {{(XLEN-SHAMT_W){1'b0}}, ex_q.sh_amt};
  assign bus.ex_sh_b      = ex_q.sh_b;
  assign bus.ex_alu_op    = ex_q.alu_op;
  assign bus.ex_rd_addr   = ex_q.rd_addr;
  assign bus.ex_reg_write = ex_q.reg_write;

endmodule

// File: tb/tb_id_ex_shift_stage.sv
// Self-checking bench for id_ex_shift_stage: directed scenarios plus a
// randomized run, all checked against a behavioural model of the stage.
module tb_id_ex_shift_stage;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  id_ex_shift_stage_if bus ();

  id_ex_shift_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation still running at %0t, required finish", $time);
    $fatal(1, "timeout");
  end

  // ---------------- behavioural model ----------------
  logic        exp_valid;
  logic [31:0] exp_a;
  logic [31:0] exp_b;
  logic [3:0]  exp_op;
  logic [4:0]  exp_rd;
  logic        exp_we;

  function automatic logic [31:0] resolve(input logic [4:0] idx, input logic [31:0] rf);
    if (bus.exmem_reg_write && bus.exmem_rd != 0 && bus.exmem_rd == idx) return bus.exmem_result;
    if (bus.memwb_reg_write && bus.memwb_rd != 0 && bus.memwb_rd == idx) return bus.memwb_result;
    return rf;
  endfunction

  task automatic model_clear();
    exp_valid = 0; exp_a = 0; exp_b = 0; exp_op = 0; exp_rd = 0; exp_we = 0;
  endtask

  // What EX should hold after the coming rising edge, given current inputs.
  task automatic model_edge();
    if (!rst_n || bus.flush) begin
      model_clear();
    end else if (!bus.stall) begin
      exp_valid = bus.id_valid;
      exp_a     = bus.id_shift_var ? (resolve(bus.id_rs_addr, bus.id_rs_data) % 32)
                                   : {27'd0, bus.id_shamt};
      exp_b     = resolve(bus.id_rt_addr, bus.id_rt_data);
      exp_op    = bus.id_alu_op;
      exp_rd    = bus.id_rd_addr;
      exp_we    = bus.id_reg_write && bus.id_valid;
    end
  endtask

  function automatic logic [74:0] observed();
    return {bus.ex_valid, bus.ex_sh_a, bus.ex_sh_b, bus.ex_alu_op, bus.ex_rd_addr, bus.ex_reg_write};
  endfunction

  function automatic logic [74:0] expected();
    return {exp_valid, exp_a, exp_b, exp_op, exp_rd, exp_we};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic quiet_fwd();
    bus.exmem_rd = 0; bus.exmem_reg_write = 0; bus.exmem_result = 0;
    bus.memwb_rd = 0; bus.memwb_reg_write = 0; bus.memwb_result = 0;
  endtask

  task automatic rand_id();
    bus.id_valid        = ($urandom_range(0, 3) != 0);
    bus.id_rs_addr      = 5'($urandom_range(0, 7));
    bus.id_rt_addr      = 5'($urandom_range(0, 7));
    bus.id_rs_data      = $urandom;
    bus.id_rt_data      = $urandom;
    bus.id_shamt        = 5'($urandom);
    bus.id_shift_var    = 1'($urandom);
    bus.id_alu_op       = 4'($urandom);
    bus.id_rd_addr      = 5'($urandom);
    bus.id_reg_write    = 1'($urandom);
    bus.exmem_rd        = 5'($urandom_range(0, 7));
    bus.exmem_reg_write = 1'($urandom);
    bus.exmem_result    = $urandom;
    bus.memwb_rd        = 5'($urandom_range(0, 7));
    bus.memwb_reg_write = 1'($urandom);
    bus.memwb_result    = $urandom;
  endtask

  // Apply the currently driven inputs across one rising edge.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rand_id(); bus.stall = 1'($urandom); bus.flush = 1'($urandom);
      step();
      n_checks++;
      if (observed() !== 75'd0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got %h want 0", i, observed());
      end
    end
    @(negedge clk);
    rst_n = 1; bus.stall = 0; bus.flush = 0;
    quiet_fwd(); rand_id(); quiet_fwd();
    bus.id_valid = 1; bus.id_shift_var = 0; bus.id_shamt = 5'd4;
    bus.id_rt_data = 32'h0000_0001; bus.id_alu_op = 4'd6; bus.id_reg_write = 1;
    step();
    n_checks++;
    if (bus.ex_sh_a !== 32'd4 || bus.ex_sh_b !== 32'd1 || bus.ex_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_load: got a=%h b=%h v=%b want a=4 b=1 v=1",
               bus.ex_sh_a, bus.ex_sh_b, bus.ex_valid);
    end
    n_checks++;
    if (observed() !== expected()) begin
      n_fail++;
      $display("FAIL reset_first_load_model: got %h want %h", observed(), expected());
    end
  endtask

  task automatic test_var_mask();
    @(negedge clk);
    rand_id(); quiet_fwd();
    bus.id_valid = 1; bus.id_shift_var = 1; bus.id_rs_data = 32'hFFFF_FFE3;
    step();
    n_checks++;
    if (bus.ex_sh_a !== 32'h0000_0003) begin
      n_fail++;
      $display("FAIL var_mask: got %h want 00000003", bus.ex_sh_a);
    end
    // rs forwarded from EX/MEM with a value above 31: sllv by 0x21 is by 1
    @(negedge clk);
    rand_id();
    bus.id_shift_var = 1; bus.id_rs_addr = 5'd3;
    bus.exmem_rd = 5'd3; bus.exmem_reg_write = 1; bus.exmem_result = 32'h0000_0021;
    step();
    n_checks++;
    if (bus.ex_sh_a !== 32'h0000_0001) begin
      n_fail++;
      $display("FAIL var_mask_fwd: got %h want 00000001", bus.ex_sh_a);
    end
  endtask

  task automatic test_forward_priority();
    logic [31:0] want [4];
    want[0] = 32'hAAAA_0000; want[1] = 32'h1234_5678;
    want[2] = 32'h0BAD_CAFE; want[3] = 32'h0BAD_CAFE;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rand_id();
      bus.id_valid = 1; bus.id_rt_addr = 5'd5; bus.id_rt_data = 32'h0BAD_CAFE;
      bus.exmem_rd = 5'd5; bus.exmem_reg_write = 1; bus.exmem_result = 32'hAAAA_0000;
      bus.memwb_rd = 5'd5; bus.memwb_reg_write = 1; bus.memwb_result = 32'h1234_5678;
      if (i >= 1) bus.exmem_reg_write = 0;
      if (i == 2) begin bus.exmem_rd = 0; bus.memwb_rd = 0; bus.exmem_reg_write = 1; end
      if (i == 3) begin   // r0 as a source with writers claiming r0
        bus.id_rt_addr = 0; bus.exmem_rd = 0; bus.memwb_rd = 0; bus.exmem_reg_write = 1;
      end
      step();
      n_checks++;
      if (bus.ex_sh_b !== want[i]) begin
        n_fail++;
        $display("FAIL fwd_priority[%0d]: got %h want %h", i, bus.ex_sh_b, want[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [74:0] held;
    @(negedge clk);
    rand_id(); bus.id_valid = 1; bus.id_reg_write = 1;
    step();
    n_checks++;
    if (observed() !== expected()) begin
      n_fail++;
      $display("FAIL stall_load: got %h want %h", observed(), expected());
    end
    held = expected();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rand_id(); bus.stall = 1;
      step();
      n_checks++;
      if (observed() !== held) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got %h want %h", i, observed(), held);
      end
    end
    @(negedge clk);
    rand_id(); bus.stall = 0;
    step();
    n_checks++;
    if (observed() !== expected()) begin
      n_fail++;
      $display("FAIL stall_release: got %h want %h", observed(), expected());
    end
  endtask

  task automatic test_flush_stall();
    @(negedge clk);
    rand_id(); bus.id_valid = 1; bus.id_reg_write = 1;
    step();
    @(negedge clk);
    rand_id(); bus.stall = 1; bus.flush = 1;
    step();
    n_checks++;
    if (bus.ex_valid !== 1'b0 || bus.ex_reg_write !== 1'b0 ||
        bus.ex_sh_a !== 32'd0 || bus.ex_sh_b !== 32'd0) begin
      n_fail++;
      $display("FAIL flush_stall: got v=%b we=%b a=%h b=%h want all 0",
               bus.ex_valid, bus.ex_reg_write, bus.ex_sh_a, bus.ex_sh_b);
    end
    n_checks++;
    if (observed() !== expected()) begin
      n_fail++;
      $display("FAIL flush_stall_model: got %h want %h", observed(), expected());
    end
    @(negedge clk);
    bus.stall = 0; bus.flush = 0;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    rand_id(); bus.id_valid = 1; bus.id_reg_write = 1; bus.id_rt_data = 32'hFFFF_FFFF;
    bus.id_rt_addr = 0;
    step();
    n_checks++;
    if (bus.ex_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL async_preload: got v=%b want 1", bus.ex_valid);
    end
    #2;
    rst_n = 0;
    model_clear();
    #1;
    n_checks++;
    if (observed() !== 75'd0) begin
      n_fail++;
      $display("FAIL async_clear: got %h want 0 (no clock edge seen)", observed());
    end
    @(negedge clk);
    rst_n = 1;
    rand_id(); bus.id_valid = 1;
    step();
    n_checks++;
    if (observed() !== expected()) begin
      n_fail++;
      $display("FAIL async_first_load: got %h want %h", observed(), expected());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      rand_id();
      bus.stall = ($urandom_range(0, 4) == 0);
      bus.flush = ($urandom_range(0, 7) == 0);
      step();
      n_checks++;
      if (observed() !== expected()) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h want %h", i, observed(), expected());
      end
    end
    @(negedge clk);
    bus.stall = 0; bus.flush = 0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 0;
    bus.stall = 0;
    bus.flush = 0;
    rand_id();
    model_clear();
    test_reset();
    test_var_mask();
    test_forward_priority();
    test_stall();
    test_flush_stall();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_shift_stage.md
Name: id_ex_shift_stage

Overview:
- ID/EX pipeline register for shift-class instructions in the 5-stage CPU. It captures decoded operands and control at the ID/EX boundary and registers the operand pair consumed by the EX-stage 32-bit left shifter: A is the shift amount, B is the value shifted.
- Resolves the shift amount from either the instruction shamt field or rs[4:0]. Applies EX/MEM and MEM/WB forwarding at capture.
- Handles stall (hold) and flush (bubble).

Parameters:
- XLEN, 32, datapath width.
- RADDR_W, 5, register-address width.
- ALUOP_W, 4, ALU operation code width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold current EX contents (load-use hazard).
- flush  in  1  replace next EX contents with a bubble (branch taken / exception).
- id_valid  in  1  ID holds a real instruction.
- id_rs_addr  in  RADDR_W  rs index.
- id_rt_addr  in  RADDR_W  rt index.
- id_rs_data  in  XLEN  register-file rs read.
- id_rt_data  in  XLEN  register-file rt read.
- id_shamt  in  5  instruction shamt field.
- id_shift_var  in  1  1 = variable shift (amount from rs), 0 = amount from shamt.
- id_alu_op  in  ALUOP_W  EX operation select.
- id_rd_addr  in  RADDR_W  destination index.
- id_reg_write  in  1  destination write enable.
- exmem_rd  in  RADDR_W  EX/MEM destination.
- exmem_reg_write  in  1  EX/MEM write enable.
- exmem_result  in  XLEN  EX/MEM result.
- memwb_rd  in  RADDR_W  MEM/WB destination.
- memwb_reg_write  in  1  MEM/WB write enable.
- memwb_result  in  XLEN  MEM/WB result.
- ex_valid  out  1  EX holds a real instruction.
- ex_sh_a  out  XLEN  shift amount, zero-extended.
- ex_sh_b  out  XLEN  value to shift.
- ex_alu_op  out  ALUOP_W  registered operation.
- ex_rd_addr  out  RADDR_W  registered destination.
- ex_reg_write  out  1  registered write enable, gated by valid.

Behaviour:
- Reset: rst_n low asynchronously clears all outputs to 0 (ex_valid=0, ex_sh_a=0, ex_sh_b=0, ex_alu_op=0, ex_rd_addr=0, ex_reg_write=0). Reset asserted mid-operation discards in-flight contents immediately.
- Latency: 1 cycle. Values present at ID on a rising edge appear on ex_* after that edge.
- Priority per edge: reset > flush > stall > load.
  - flush: load a bubble (ex_valid=0, ex_reg_write=0, ex_sh_a=0, ex_sh_b=0, ex_alu_op=0, ex_rd_addr=0). Flush wins over a simultaneous stall.
  - stall (no flush): all ex_* hold their previous values.
  - load: capture resolved values; ex_valid=id_valid; ex_reg_write=id_reg_write & id_valid.
- Forwarding: applied to rs and rt independently, before capture.
  - Use exmem_result if exmem_reg_write=1, exmem_rd≠0 and exmem_rd equals the source index.
  - Else use memwb_result under the same rule with the memwb_* inputs.
  - Else use the register-file data.
  - EX/MEM has priority over MEM/WB. Index 0 is never forwarded.
- Shift amount:
  - ex_sh_a = {27'b0, fwd_rs[4:0]} when id_shift_var=1.
  - ex_sh_a = {27'b0, id_shamt} when id_shift_var=0.
  - Upper 27 bits are always 0. The downstream shifter shifts by the full A, so masking here is mandatory (sllv by rs=0x0000_0021 shifts by 1, not 33).
- ex_sh_b = forwarded rt.
- Bubble vs. invalid input: id_valid=0 on a load captures the operands but forces ex_valid=0 and ex_reg_write=0.

Decomposition:
- Shared package pipe_pkg holds:
  - constants XLEN, RADDR_W, ALUOP_W, SHAMT_W=5;
  - ALU op codes (ALU_SLL, ALU_SRL, ALU_SRA, ...);
  - REG_ZERO=0.
- One sub-module, fwd_mux: a combinational 3-way forwarding select (source index, register-file data, EX/MEM and MEM/WB tuples → data). It is instantiated twice, once for rs and once for rt.

Test Plan:
- Reset: hold rst_n=0 with random inputs → all outputs 0. Release, then load sll with shamt=4, rt=0x0000_0001, id_valid=1 → next cycle ex_sh_a=4, ex_sh_b=0x0000_0001, ex_valid=1.
- Variable masking: id_shift_var=1, rs=0xFFFF_FFE3 → ex_sh_a=0x0000_0003.
- Forward priority: rt=5 with exmem_rd=5/exmem_result=0xAAAA_0000 and memwb_rd=5/memwb_result=0x1234_5678, both writing → ex_sh_b=0xAAAA_0000. Drop exmem_reg_write → 0x1234_5678. Set all rd=0 → register-file value used.
- Stall: load instr X, then hold stall=1 for 3 cycles while ID changes → ex_* equal X for all 3 cycles. Deassert stall → new ID values appear 1 cycle later.
- Flush + stall together: stall=1, flush=1 while EX holds a valid instr → next cycle ex_valid=0, ex_reg_write=0, ex_sh_a=0, ex_sh_b=0.
- Async reset mid-stream: drop rst_n between clock edges with ex_valid=1 → outputs clear without waiting for a clock edge. Release → the first load captures correctly.
